// File: rtl/led_pkg.sv
// Shared constants for the LED ping-pong step generator and shifter top.
// speed_sel encoding, default clock/divider/debounce values, period helper.
package led_pkg;

    localparam int SPEED_W = 2;

    localparam logic [SPEED_W-1:0] SPD_2HZ  = 2'd0;
    localparam logic [SPEED_W-1:0] SPD_4HZ  = 2'd1;
    localparam logic [SPEED_W-1:0] SPD_8HZ  = 2'd2;
    localparam logic [SPEED_W-1:0] SPD_16HZ = 2'd3;

    localparam int DEF_CLK_HZ     = 50_000_000;
    localparam int DEF_BASE_DIV   = 25_000_000;
    localparam int DEF_DEB_CYCLES = 500_000;

    // Each speed step halves the tick period.
    function automatic logic [31:0] period_of(input logic [31:0] base,
                                              input logic [SPEED_W-1:0] sel);
        return base >> sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: polarity normalize, 2-FF sync, stable-count debounce,
// and a one-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int DEB_CYCLES = 500_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          norm;
    logic          s1, s2, level_d;
    logic [DW-1:0] cnt;

    assign norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // Level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= norm;
            s2      <= s1;
            level_d <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press_pulse = level & ~level_d;

endmodule

// File: rtl/led_step_gen.sv
// Step-enable pulse generator for the LED shifter: switch-selected period, button run/pause.
// Define LED_SINGLE_STEP_EN to add btn_step, which emits one tick per press while paused.
module led_step_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int BASE_DIV       = DEF_BASE_DIV,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               btn_pause,
`ifdef LED_SINGLE_STEP_EN
    input  logic               btn_step,
`endif
    output logic               tick,
    output logic               running
);

    localparam int CW = $clog2(BASE_DIV);

    if (BASE_DIV < 8 || CLK_HZ <= 0) begin : g_bad_cfg
        $error("led_step_gen: BASE_DIV must be >= 8 and CLK_HZ positive");
    end

    logic [SPEED_W-1:0] sel_s1, sel_sync;
    logic [CW-1:0]      cnt;
    logic [31:0]        period;
    logic               at_end;
    logic               pause_level, pause_press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_pause (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_pause),
        .level       (pause_level),
        .press_pulse (pause_press)
    );

    assign period = period_of(32'(BASE_DIV), sel_sync);
    // >= rather than == so a shorter period picked mid-count fires at once.
    assign at_end = (32'(cnt) >= (period - 32'd1));

`ifdef LED_SINGLE_STEP_EN
    logic step_level, step_press, step_go, step_fire;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_step (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_step),
        .level       (step_level),
        .press_pulse (step_press)
    );

    // A simultaneous pause toggle takes priority over the step.
    assign step_go = step_press & ~running & ~pause_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_fire <= 1'b0;
        else     step_fire <= step_go;
    end

    assign tick = (running & at_end) | step_fire;
`else
    assign tick = running & at_end;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_s1   <= '0;
            sel_sync <= '0;
            running  <= 1'b1;
            cnt      <= '0;
        end else begin
            sel_s1   <= speed_sel;
            sel_sync <= sel_s1;
            if (pause_press)
                running <= ~running;
            if (running)
                cnt <= at_end ? '0 : cnt + 1'b1;
`ifdef LED_SINGLE_STEP_EN
            if (step_go)
                cnt <= '0;
`endif
        end
    end

endmodule
